// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS main control unit.
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Twelve used encodings; 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    // Full set of datapath controls produced by one state
    typedef struct packed {
        logic       memwrite;
        logic       memread;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       pcen;
        logic [1:0] pcsource;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       regwrite;
        logic       irwrite;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_control_outdec.sv
// Moore output decoder: maps the current control state to datapath controls.
module mips_control_outdec
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Every control defaults to 0; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.irwrite  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                ctrl.pcen     = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            // pcen stays 0: the datapath qualifies the branch write with zero.
            S_BEQEX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_REG;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
            end
            S_JEX: begin
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.pcen     = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_control.sv
// Main control FSM of the multicycle MIPS: sequences each instruction.
//
// state   | meaning
// FETCH   | read instruction at PC, load IR, PC <= PC + 4
// DECODE  | read registers, precompute branch target into ALUOut
// MEMADR  | compute load/store address A + imm
// MEMRD   | read data memory at ALUOut
// MEMWB   | write memory data into rt
// MEMWR   | write B into data memory at ALUOut
// RTYPEEX | ALU operation on A, B selected by funct
// RTYPEWB | write ALUOut into rd
// BEQEX   | compare A - B, branch to ALUOut when zero
// JEX     | load jump target into PC
// ADDIEX  | compute A + imm
// ADDIWB  | write ALUOut into rt
module mips_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       memwrite,
    output logic       memread,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       regwrite,
    output logic       irwrite,
    output logic [1:0] aluop
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_J:         state_next = S_JEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    mips_control_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign memwrite = ctrl.memwrite;
    assign memread  = ctrl.memread;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcen     = ctrl.pcen;
    assign pcsource = ctrl.pcsource;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign iord     = ctrl.iord;
    assign regwrite = ctrl.regwrite;
    assign irwrite  = ctrl.irwrite;
    assign aluop    = ctrl.aluop;

endmodule

// File: tb/tb_mips_control.sv
// Self-checking bench for mips_control: per-instruction expected output
// sequences, checked every cycle, plus directed latency/literal checks.
module tb_mips_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       memwrite, memread, alusrca, pcen, memtoreg, regdst, iord, regwrite, irwrite;
    logic [1:0] alusrcb, pcsource, aluop;

    mips_control dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memwrite (memwrite),
        .memread  (memread),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcen     (pcen),
        .pcsource (pcsource),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .iord     (iord),
        .regwrite (regwrite),
        .irwrite  (irwrite),
        .aluop    (aluop)
    );

    // {memwrite, memread, alusrca, alusrcb, pcen, pcsource, memtoreg, regdst, iord, regwrite, irwrite, aluop}
    logic [14:0] outv;
    assign outv = {memwrite, memread, alusrca, alusrcb, pcen, pcsource,
                   memtoreg, regdst, iord, regwrite, irwrite, aluop};

    //                             mw    mr    asa   asb    pcen  pcs    m2r   rdst  iord  rw    irw   aluop
    localparam logic [14:0] V_F  = {1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    localparam logic [14:0] V_D  = {1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_MA = {1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_MR = {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_MB = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    localparam logic [14:0] V_MW = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_RE = {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    localparam logic [14:0] V_RW = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    localparam logic [14:0] V_BQ = {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    localparam logic [14:0] V_J  = {1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_AE = {1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam logic [14:0] V_AW = {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] expq[$];
    int          pos;
    logic [14:0] seen[0:15];

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level model: each instruction is FETCH, DECODE, then an
    // opcode-dependent tail chosen when the DECODE cycle completes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            expq = {V_F, V_D};
            pos  = 0;
        end else if (expq.size() > 0) begin
            void'(expq.pop_front());
            if (pos == 1) begin
                case (op)
                    6'b100011: begin expq.push_back(V_MA); expq.push_back(V_MR); expq.push_back(V_MB); end
                    6'b101011: begin expq.push_back(V_MA); expq.push_back(V_MW); end
                    6'b000000: begin expq.push_back(V_RE); expq.push_back(V_RW); end
                    6'b000100: expq.push_back(V_BQ);
                    6'b000010: expq.push_back(V_J);
                    6'b001000: begin expq.push_back(V_AE); expq.push_back(V_AW); end
                    default: ;
                endcase
            end
            pos++;
            if (expq.size() == 0) begin
                expq = {V_F, V_D};
                pos  = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (expq.size() > 0) check("cycle_outputs", outv, expq[0]);
    end

    // Called at a negedge inside FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [5:0] opc, input int lat, input string name);
        int  n;
        bit  done;
        op      = opc;
        seen[0] = outv;
        n       = 1;
        done    = 1'b0;
        while (!done && n < 12) begin
            @(negedge clk);
            if (outv[2]) done = 1'b1;
            else begin
                seen[n] = outv;
                n++;
            end
        end
        check_int({name, "_latency"}, n, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        repeat (2) @(negedge clk);
        check("reset_fetch", outv, V_F);
        #1;
        op    = 6'b111111;
        reset = 1'b0;
        @(negedge clk);
        check("release_decode", outv, V_D);
        @(negedge clk);
        check("illegal_back_to_fetch", outv, V_F);

        run_instr(6'b100011, 5, "lw");
        check("lw_memadr", seen[2], V_MA);
        check("lw_memrd",  seen[3], V_MR);
        check("lw_memwb",  seen[4], V_MB);

        run_instr(6'b101011, 4, "sw");
        check("sw_memwr", seen[3], V_MW);
        check("sw_no_regwrite", {14'd0, seen[0][3] | seen[1][3] | seen[2][3] | seen[3][3]}, 15'd0);

        run_instr(6'b000000, 4, "rtype");
        check("rtype_ex", seen[2], V_RE);
        check("rtype_wb", seen[3], V_RW);

        run_instr(6'b001000, 4, "addi");
        check("addi_ex", seen[2], V_AE);
        check("addi_wb", seen[3], V_AW);

        run_instr(6'b000100, 3, "beq");
        check("beq_ex", seen[2], V_BQ);

        run_instr(6'b000010, 3, "j");
        check("j_ex", seen[2], V_J);

        run_instr(6'b111111, 2, "illegal_3f");
        run_instr(6'b000011, 2, "illegal_03");
        run_instr(6'b100011, 5, "lw_again");

        // Abort a load in MEMRD with an asynchronous reset.
        op = 6'b100011;
        repeat (3) @(negedge clk);
        check("pre_abort_memrd", outv, V_MR);
        #1 reset = 1'b1;
        #1 check("abort_immediate_fetch", outv, V_F);
        @(posedge clk);
        #1 check("abort_held_fetch", outv, V_F);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_release_decode", outv, V_D);

        // Let the restarted load finish, bounded.
        begin
            int  k;
            bit  back;
            k    = 0;
            back = 1'b0;
            while (!back && k < 10) begin
                @(negedge clk);
                if (outv[2]) back = 1'b1;
                k++;
            end
            check_int("restart_lw_cycles_to_fetch", k, 4);
        end
        run_instr(6'b000010, 3, "j_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_control.md
Name: mips_control

Overview:
- Main control unit of the multicycle MIPS processor.
- A Moore finite-state machine that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, every memory and register-file enable, and the ALU-op code sent to the ALU decoder.
- Decodes only the 6-bit primary opcode; funct decoding stays in the separate ALU decoder.

Parameters:
- none (opcodes and state encodings are package constants)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  6  instruction opcode, instr[31:26], from the instruction register
- memwrite  output  1  memory write enable
- memread  output  1  memory read enable
- alusrca  output  1  ALU A select: 0=PC, 1=register A
- alusrcb  output  2  ALU B select: 00=register B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
- pcen  output  1  unconditional PC write enable
- pcsource  output  2  next-PC select: 00=ALU result, 01=ALUOut (branch target), 10=jump target
- memtoreg  output  1  register write data select: 0=ALUOut, 1=memory data register
- regdst  output  1  write register select: 0=rt, 1=rd
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- regwrite  output  1  register-file write enable
- irwrite  output  1  instruction-register load enable
- aluop  output  2  00=add, 01=subtract, 10=use funct field

Behaviour:
- Single clock domain. State register is updated on rising clk and reset asynchronously to FETCH by reset=1.
- All outputs are a pure function of the current state (Moore). op affects only next-state logic. Every output not listed for a state is 0.
- While reset is asserted, and in the first cycle after release, outputs equal the FETCH outputs.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.

States, outputs and transitions:
- FETCH: memread=1, irwrite=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00, pcen=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - LW or SW -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - J -> JEX
  - ADDI -> ADDIEX
  - any other opcode -> FETCH (illegal opcode is ignored; no register or memory side effects)
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=LW, MEMWR if op=SW.
- MEMRD: memread=1, iord=1. Next: MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next: FETCH.
- MEMWR: memwrite=1, iord=1. Next: FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=0. Next: FETCH.
  - The datapath forms the branch write as (pcsource==01 & zero) ORed with pcen; this block has no zero input.
- JEX: pcsource=10, pcen=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
- Unused state encodings go to FETCH, with all outputs 0.

Latency (cycles per instruction):
- LW: 5
- SW, RTYPE, ADDI: 4
- BEQ, J: 3
- illegal opcode: 2

Reset mid-instruction aborts the sequence immediately: outputs show FETCH values in the same cycle, with no pending write.

op must be stable from DECODE through the last state of the instruction; the IR is not loaded outside FETCH.

Decomposition:
- Package mips_pkg:
  - opcode localparams
  - enum typedef for the 12 states (4-bit encoding)
  - constants for the alusrcb, pcsource and aluop codes
- Optional sub-module mips_control_outdec: combinational state -> output-vector decoder, so that next-state logic and output decode stay separate.

Test Plan:
- reset=1 with op=000000 -> memread=1, irwrite=1, pcen=1, alusrcb=01, all others 0; deassert reset -> DECODE outputs next cycle (alusrcb=11, all others 0).
- op=100011 (LW) -> FETCH, DECODE, MEMADR (alusrca=1, alusrcb=10), MEMRD (memread=1, iord=1), MEMWB (regwrite=1, memtoreg=1), then FETCH.
- op=101011 (SW) -> FETCH, DECODE, MEMADR, MEMWR (memwrite=1, iord=1), then FETCH; regwrite stays 0 throughout.
- op=000000 (R-type) -> RTYPEEX (alusrca=1, alusrcb=00, aluop=10), then RTYPEWB (regwrite=1, regdst=1); op=001000 (ADDI) -> ADDIEX (alusrcb=10), then ADDIWB (regwrite=1, regdst=0).
- op=000100 (BEQ) -> BEQEX (alusrca=1, aluop=01, pcsource=01, pcen=0); op=000010 (J) -> JEX (pcsource=10, pcen=1); both return to FETCH on the next cycle.
- op=111111 in DECODE -> FETCH next cycle; reset asserted in MEMRD -> FETCH outputs immediately, with no memwrite or regwrite pulse.
